// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island definitions: packet layout, slot geometry and the
// bit-serial BCH step used by every ECC lane.
package hdmi_pkg;

  localparam int PKT_BITS    = 248;
  localparam int SLOT_LEN    = 32;
  localparam int HEADER_BITS = 24;
  localparam int SUB_BITS    = 56;
  localparam int NUM_SUB     = 4;

  typedef struct packed {
    logic [NUM_SUB*SUB_BITS-1:0] sub;
    logic [HEADER_BITS-1:0]      header;
  } pkt_t;

  localparam logic [HEADER_BITS-1:0] NULL_HEADER = '0;
  localparam pkt_t NULL_PKT = '{sub: '0, header: NULL_HEADER};

  function automatic logic [7:0] next_ecc(input logic [7:0] ecc,
                                          input logic       bit_in,
                                          input logic [7:0] poly);
    return (ecc[0] ^ bit_in) ? ((ecc >> 1) ^ poly) : (ecc >> 1);
  endfunction

endpackage

// File: rtl/bch_ecc_lane.sv
// One BCH parity register; applies BITS_PER_CYCLE serial steps per enabled
// cycle, LSB of data first. Clear wins over step.
module bch_ecc_lane
  import hdmi_pkg::*;
#(
  parameter int         BITS_PER_CYCLE = 1,
  parameter logic [7:0] ECC_POLY       = 8'h83
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step,
  input  logic                      clear,
  input  logic [BITS_PER_CYCLE-1:0] data,
  output logic [7:0]                parity
);

  logic [7:0] parity_next;

  always_comb begin
    parity_next = parity;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      parity_next = next_ecc(parity_next, data[i], ECC_POLY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= '0;
    end else if (clear) begin
      parity <= '0;
    end else if (step) begin
      parity <= parity_next;
    end
  end

endmodule

// File: rtl/packet_queue_assembler.sv
// Queues complete data-island packets and serialises one per 32-pixel slot
// with BCH parity appended; empty slots carry a null packet or stay idle.
module packet_queue_assembler
  import hdmi_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ECC_POLY   = 8'h83,
  parameter bit         NULL_FILL  = 1'b1
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          data_island_period,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [HEADER_BITS-1:0]        in_header,
  input  logic [NUM_SUB*SUB_BITS-1:0]   in_sub,
  output logic [8:0]                    packet_data,
  output logic                          packet_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SLOT_LEN);

  pkt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [CW-1:0] counter;
  pkt_t          cur_pkt;
  logic          cur_real;

  logic full, empty, push, pop, slot_start, active;

  assign full       = (count == LW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign slot_start = data_island_period && (counter == '0);
  assign push       = in_valid && !full;
  assign pop        = slot_start && !empty;
  assign active     = data_island_period && !reset;

  assign in_ready   = !full;
  assign fifo_level = count;
  assign abort      = !data_island_period && (counter != '0);

  always_ff @(posedge clk_pixel) begin
    if (push) begin
      mem[wr_ptr] <= '{sub: in_sub, header: in_header};
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dropping the island mid-slot discards the latched packet: the counter
  // returns to 0 and the next slot starts from the FIFO head.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      counter  <= '0;
      cur_pkt  <= NULL_PKT;
      cur_real <= 1'b0;
    end else begin
      counter <= data_island_period ? counter + 1'b1 : '0;
      if (slot_start) begin
        cur_pkt  <= empty ? NULL_PKT : mem[rd_ptr];
        cur_real <= !empty;
      end
    end
  end

  // Slot cycle 0 reads the head directly so the first bit leaves with no delay.
  pkt_t slot_pkt;
  logic slot_real, send;

  always_comb begin
    slot_pkt  = cur_pkt;
    slot_real = cur_real;
    if (counter == '0) begin
      slot_pkt  = empty ? NULL_PKT : mem[rd_ptr];
      slot_real = !empty;
    end
  end

  assign send = active && (slot_real || NULL_FILL);

  logic        lane_clear, hdr_step, sub_step;
  logic [7:0]  par_hdr;
  logic [31:0] bch_hdr;
  logic [7:0]  par_sub [NUM_SUB];
  logic [63:0] bch_sub [NUM_SUB];

  assign lane_clear = !data_island_period || (counter == CW'(SLOT_LEN - 1));
  assign hdr_step   = data_island_period && (counter < CW'(HEADER_BITS));
  assign sub_step   = data_island_period && (counter <= CW'(SUB_BITS / 2 - 1));
  assign bch_hdr    = {par_hdr, slot_pkt.header};

  bch_ecc_lane #(.BITS_PER_CYCLE(1), .ECC_POLY(ECC_POLY)) u_lane_hdr (
    .clk    (clk_pixel),
    .rst    (reset),
    .step   (hdr_step),
    .clear  (lane_clear),
    .data   (bch_hdr[counter]),
    .parity (par_hdr)
  );

  for (genvar k = 0; k < NUM_SUB; k++) begin : g_sub
    assign bch_sub[k] = {par_sub[k], slot_pkt.sub[k*SUB_BITS +: SUB_BITS]};

    bch_ecc_lane #(.BITS_PER_CYCLE(2), .ECC_POLY(ECC_POLY)) u_lane_sub (
      .clk    (clk_pixel),
      .rst    (reset),
      .step   (sub_step),
      .clear  (lane_clear),
      .data   (bch_sub[k][{counter, 1'b0} +: 2]),
      .parity (par_sub[k])
    );
  end

  always_comb begin
    packet_data = '0;
    if (send) begin
      packet_data[0] = bch_hdr[counter];
      for (int k = 0; k < NUM_SUB; k++) begin
        packet_data[1 + k] = bch_sub[k][{counter, 1'b0}];
        packet_data[5 + k] = bch_sub[k][{counter, 1'b1}];
      end
    end
  end

  assign packet_enable = send && (counter == '0);

endmodule

// File: doc/packet_queue_assembler.md
Name: packet_queue_assembler

Overview:
- Parametrised successor of the single-packet data-island assembler.
- Accepts complete HDMI data island packets (header plus four subpackets) through a valid/ready interface and buffers them in an internal FIFO.
- Serialises one packet per 32-pixel slot during data island periods: generates BCH ECC for the header (BCH block 4) and for the four subpackets (BCH blocks 0-3).
- Inserts a null packet when the queue is empty. Sits between the packet sources/muxer and the TERC4 channel encoders.

Parameters:
- FIFO_DEPTH, 4, number of buffered packets; power of two, 2..16.
- ECC_POLY, 8'h83, feedback term XORed into the right-shifted ECC register.
- NULL_FILL, 1, 1 = send null packet (all-zero header/subpackets) when FIFO empty; 0 = hold packet_enable low and drive zero data for that slot.

Ports:
- clk_pixel, input, 1, pixel clock; the only clock.
- reset, input, 1, asynchronous, active-high reset.
- data_island_period, input, 1, high during data island packet transmission.
- in_valid, input, 1, packet offered.
- in_ready, output, 1, FIFO can accept (= !full).
- in_header, input, 24, HB0..HB2; bit 0 transmitted first.
- in_sub, input, 224, subpacket k occupies bits [56k+55:56k].
- packet_data, output, 9, bit0 = header/BCH4 bit; bits[4:1] = even bits of BCH0..3; bits[8:5] = odd bits of BCH0..3.
- packet_enable, output, 1, high on the first cycle of each transmitted packet.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, occupied entries.
- abort, output, 1, one-cycle pulse when a slot is cut short.

Behaviour:
- Reset (async assert, sync release): slot counter=0; FIFO empty; parity regs=0; current packet=null; in_ready=1; packet_enable=0; abort=0; fifo_level=0.
- Push: entry written on a rising edge with in_valid && in_ready.
- 5-bit slot counter increments while data_island_period=1 and wraps 31->0.
- Pop at counter==0 with data_island_period=1:
  - FIFO non-empty: head popped and latched as the current packet.
  - FIFO empty: null latched; no pop.
- Same-cycle push and pop: both take effect; fifo_level unchanged. No bypass: a push into an empty FIFO is not sent in the same slot.
- During counter==0, packet_data is driven from the FIFO head (or null) combinationally. From counter 1..31 it is driven from the latched packet.
- BCH4 = {parity4, header}. BCHk = {parityk, subk}. Bit index t = counter for BCH4; 2*counter and 2*counter+1 for BCHk.
- ECC step: e' = (e[0]^b) ? (e>>1)^ECC_POLY : e>>1.
  - parity4 updates for counter 0..23.
  - parity0..3 apply two steps per cycle (even bit then odd bit) for counter 0..27.
  - All parity regs clear at counter==31.
  - Parity bits are therefore transmitted at counter 24..31 (BCH4) and 28..31 (BCH0-3).
- packet_enable = data_island_period && counter==0 && (slot is real or NULL_FILL=1).
  - NULL_FILL=0 with empty FIFO: packet_data=0 for the whole slot.
- Early end: data_island_period falling with counter!=0 → counter and parity regs clear next edge; abort pulses one cycle; the popped packet is discarded, not re-queued.
- Outputs are combinational from registered state plus the FIFO head; zero added latency relative to data_island_period.
- fifo_level never exceeds FIFO_DEPTH. in_valid while full is ignored; the source must hold it.

Decomposition:
- Shared package hdmi_pkg: PKT_BITS=248, SLOT_LEN=32, HEADER_BITS=24, SUB_BITS=56, NULL header constant, function next_ecc(ecc, bit, poly).
- Sub-module bch_ecc_lane: one 8-bit parity register; parameter for bits per cycle (1 or 2); input a step-enable and a clear. Instantiated 5 times (one header lane at 1 bit/cycle, four subpacket lanes at 2 bits/cycle).
- FIFO is inline register array with wrap-around pointers.

Test Plan:
- Reset, data_island_period=1 for 64 cycles, empty FIFO, NULL_FILL=1 → packet_enable at cycles 0 and 32; packet_data=9'h000 every cycle; abort=0.
- Push header=24'h000001, subs=0, then island 32 cycles → cycle 0 packet_data[0]=1; parity4 matches bit-serial golden model (ECC_POLY 8'h83) on cycles 24..31; bits[8:1] of packet_data=0 for cycles 0..27.
- Push 5 packets back-to-back with no island, FIFO_DEPTH=4 → in_ready=0 after 4th accept; fifo_level=4; 5th held; one slot later fifo_level 4→3→4 as the held packet enters.
- Random header/sub stream over 8 consecutive slots → every packet_data bit, including parity bits at counter 24..31 and 28..31, equals the golden model; FIFO order preserved.
- Drop data_island_period at counter=10 → abort pulses once; next island restarts at counter 0 with parity 0; the dropped packet is not resent.
- Assert reset at counter=17 with 2 queued → immediately fifo_level=0, packet_enable=0, in_ready=1; after release the first slot carries null.
